food_controller: RTL and testbench

Owns the snake game's single food item. Sits directly downstream of `random_generator`: it samples `randomX`/`randomY`, validates each candidate, and holds the accepted position. It then detects the snake head landing on the food, counts score, and drives the VGA renderer through a draw/erase request handshake.

---
 rtl/snake_pkg.sv | 25 ++
 rtl/food_pos_check.sv | 41 ++++
 rtl/food_controller.sv | 148 ++++++++++++++
 tb/tb_food_controller.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | snake_pkg: shared FSM state type and screen/grid constants              |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package snake_pkg;

  localparam int          C_X_W       = 10;
  localparam int          C_Y_W       = 9;
  localparam int unsigned C_GRID      = 10;
  localparam int unsigned C_MAX_X     = 630;
  localparam int unsigned C_MAX_Y     = 470;
  localparam int unsigned C_DEFAULT_X = 320;
  localparam int unsigned C_DEFAULT_Y = 240;
  localparam int unsigned C_MAX_TRIES = 8;

  typedef enum logic [1:0] {
    ST_SPAWN  = 2'd0,
    ST_DRAW   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_ERASE  = 2'd3
  } food_state_e;

endpackage
`default_nettype wire

// File: rtl/food_pos_check.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | food_pos_check: combinational validator for a food position candidate  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module food_pos_check
  import snake_pkg::*;
#(
  parameter int unsigned GRID  = C_GRID,
  parameter int unsigned MAX_X = C_MAX_X,
  parameter int unsigned MAX_Y = C_MAX_Y
) (
  input  logic [C_X_W-1:0] cand_x_i,
  input  logic [C_Y_W-1:0] cand_y_i,
  input  logic [C_X_W-1:0] head_x_i,
  input  logic [C_Y_W-1:0] head_y_i,
  input  logic [C_X_W-1:0] food_x_i,
  input  logic [C_Y_W-1:0] food_y_i,
  output logic             ok_o
);

  localparam logic [C_X_W-1:0] C_LIM_X  = C_X_W'(MAX_X);
  localparam logic [C_Y_W-1:0] C_LIM_Y  = C_Y_W'(MAX_Y);
  localparam logic [C_X_W-1:0] C_GRID_X = C_X_W'(GRID);
  localparam logic [C_Y_W-1:0] C_GRID_Y = C_Y_W'(GRID);

  logic w_in_range;
  logic w_on_grid;
  logic w_not_head;
  logic w_not_food;

  assign w_in_range = (cand_x_i <= C_LIM_X) && (cand_y_i <= C_LIM_Y);
  assign w_on_grid  = ((cand_x_i % C_GRID_X) == {C_X_W{1'b0}})
                   && ((cand_y_i % C_GRID_Y) == {C_Y_W{1'b0}});
  assign w_not_head = (cand_x_i != head_x_i) || (cand_y_i != head_y_i);
  assign w_not_food = (cand_x_i != food_x_i) || (cand_y_i != food_y_i);

  assign ok_o = w_in_range && w_on_grid && w_not_head && w_not_food;

endmodule
`default_nettype wire

// File: rtl/food_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | food_controller: spawns, tracks, scores and renders the single food    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module food_controller
  import snake_pkg::*;
#(
  parameter int unsigned GRID      = C_GRID,
  parameter int unsigned MAX_X     = C_MAX_X,
  parameter int unsigned MAX_Y     = C_MAX_Y,
  parameter int unsigned DEFAULT_X = C_DEFAULT_X,
  parameter int unsigned DEFAULT_Y = C_DEFAULT_Y,
  parameter int unsigned MAX_TRIES = C_MAX_TRIES,
  parameter int          SCORE_W   = 8
) (
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic [C_X_W-1:0]   randomX,
  input  logic [C_Y_W-1:0]   randomY,
  input  logic [C_X_W-1:0]   snakeX,
  input  logic [C_Y_W-1:0]   snakeY,
  input  logic               head_valid,
  output logic [C_X_W-1:0]   foodX,
  output logic [C_Y_W-1:0]   foodY,
  output logic               food_valid,
  output logic               food_eaten,
  output logic [SCORE_W-1:0] score,
  output logic               draw_req,
  output logic               draw_erase,
  input  logic               draw_ack
);

  localparam int               TRY_W      = $clog2(MAX_TRIES) + 1;
  localparam logic [TRY_W-1:0] C_LAST_TRY = TRY_W'(MAX_TRIES - 1);
  localparam logic [C_X_W-1:0] C_DEF_X    = C_X_W'(DEFAULT_X);
  localparam logic [C_Y_W-1:0] C_DEF_Y    = C_Y_W'(DEFAULT_Y);
  localparam logic [C_X_W-1:0] C_ALT_X    = C_X_W'(DEFAULT_X + GRID);

  food_state_e        state_q, state_d;
  logic [C_X_W-1:0]   food_x_q, food_x_d;
  logic [C_Y_W-1:0]   food_y_q, food_y_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               eaten_q, eaten_d;

  logic w_cand_ok;
  logic w_head_hit;
  logic w_default_blocked;

  food_pos_check #(
    .GRID  (GRID),
    .MAX_X (MAX_X),
    .MAX_Y (MAX_Y)
  ) u_food_pos_check (
    .cand_x_i (randomX),
    .cand_y_i (randomY),
    .head_x_i (snakeX),
    .head_y_i (snakeY),
    .food_x_i (food_x_q),
    .food_y_i (food_y_q),
    .ok_o     (w_cand_ok)
  );

  assign w_head_hit        = head_valid && (snakeX == food_x_q) && (snakeY == food_y_q);
  assign w_default_blocked = (snakeX == C_DEF_X) && (snakeY == C_DEF_Y);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_SPAWN;
      food_x_q <= C_DEF_X;
      food_y_q <= C_DEF_Y;
      tries_q  <= '0;
      score_q  <= '0;
      eaten_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      food_x_q <= food_x_d;
      food_y_q <= food_y_d;
      tries_q  <= tries_d;
      score_q  <= score_d;
      eaten_q  <= eaten_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    food_x_d = food_x_q;
    food_y_d = food_y_q;
    tries_d  = tries_q;
    score_d  = score_q;
    eaten_d  = 1'b0;
    case (state_q)
      ST_SPAWN: begin
        if (w_cand_ok) begin
          food_x_d = randomX;
          food_y_d = randomY;
          tries_d  = '0;
          state_d  = ST_DRAW;
        end else if (tries_q == C_LAST_TRY) begin
          // Out of tries: fall back, stepping one cell right if the head sits there.
          food_x_d = w_default_blocked ? C_ALT_X : C_DEF_X;
          food_y_d = C_DEF_Y;
          tries_d  = '0;
          state_d  = ST_DRAW;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      ST_DRAW: begin
        if (draw_ack) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (w_head_hit) begin
          eaten_d = 1'b1;
          if (score_q != {SCORE_W{1'b1}}) score_d = score_q + 1'b1;
          state_d = ST_ERASE;
        end
      end
      ST_ERASE: begin
        if (draw_ack) state_d = ST_SPAWN;
      end
      default: state_d = ST_SPAWN;
    endcase
  end

  always_comb begin
    draw_req   = 1'b0;
    draw_erase = 1'b0;
    food_valid = 1'b0;
    case (state_q)
      ST_DRAW:   draw_req = 1'b1;
      ST_ACTIVE: food_valid = 1'b1;
      ST_ERASE: begin
        draw_req   = 1'b1;
        draw_erase = 1'b1;
      end
      default: ;
    endcase
  end

  assign foodX      = food_x_q;
  assign foodY      = food_y_q;
  assign score      = score_q;
  assign food_eaten = eaten_q;

endmodule
`default_nettype wire

// File: tb/tb_food_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_food_controller: directed self-checking bench for food_controller   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_food_controller;

  logic       clk;
  logic       resetn;
  logic [9:0] randomX;
  logic [8:0] randomY;
  logic [9:0] snakeX;
  logic [8:0] snakeY;
  logic       head_valid;
  logic [9:0] foodX;
  logic [8:0] foodY;
  logic       food_valid;
  logic       food_eaten;
  logic [7:0] score;
  logic       draw_req;
  logic       draw_erase;
  logic       draw_ack;

  int checks;
  int errors;

  logic [9:0] cur_x;
  logic [8:0] cur_y;

  food_controller dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .randomX    (randomX),
    .randomY    (randomY),
    .snakeX     (snakeX),
    .snakeY     (snakeY),
    .head_valid (head_valid),
    .foodX      (foodX),
    .foodY      (foodY),
    .food_valid (food_valid),
    .food_eaten (food_eaten),
    .score      (score),
    .draw_req   (draw_req),
    .draw_erase (draw_erase),
    .draw_ack   (draw_ack)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and land 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    resetn     = 1'b0;
    randomX    = 10'd0;
    randomY    = 9'd0;
    snakeX     = 10'd0;
    snakeY     = 9'd0;
    head_valid = 1'b0;
    draw_ack   = 1'b0;
    #35;

    check("rst_foodX", 32'(foodX), 32'd320);
    check("rst_foodY", 32'(foodY), 32'd240);
    check("rst_food_valid", 32'(food_valid), 32'd0);
    check("rst_food_eaten", 32'(food_eaten), 32'd0);
    check("rst_draw_req", 32'(draw_req), 32'd0);
    check("rst_draw_erase", 32'(draw_erase), 32'd0);
    check("rst_score", 32'(score), 32'd0);

    // First spawn with immediate ack.
    randomX  = 10'd100;
    randomY  = 9'd50;
    draw_ack = 1'b1;
    step();
    resetn = 1'b1;
    step();
    check("spawn_foodX", 32'(foodX), 32'd100);
    check("spawn_foodY", 32'(foodY), 32'd50);
    check("spawn_draw_req", 32'(draw_req), 32'd1);
    check("spawn_draw_erase", 32'(draw_erase), 32'd0);
    check("spawn_not_valid_yet", 32'(food_valid), 32'd0);
    step();
    check("drawn_food_valid", 32'(food_valid), 32'd1);
    check("drawn_draw_req", 32'(draw_req), 32'd0);

    // Non-matching head is ignored.
    draw_ack   = 1'b0;
    snakeX     = 10'd110;
    snakeY     = 9'd50;
    head_valid = 1'b1;
    step();
    check("miss_food_valid", 32'(food_valid), 32'd1);
    check("miss_food_eaten", 32'(food_eaten), 32'd0);

    // Eat, then hold ERASE for 20 cycles with matching heads arriving.
    snakeX = 10'd100;
    step();
    check("eat_pulse", 32'(food_eaten), 32'd1);
    check("eat_score", 32'(score), 32'd1);
    check("eat_food_valid", 32'(food_valid), 32'd0);
    check("erase_req", 32'(draw_req), 32'd1);
    check("erase_flag", 32'(draw_erase), 32'd1);
    check("erase_foodX", 32'(foodX), 32'd100);
    check("erase_foodY", 32'(foodY), 32'd50);
    for (int i = 0; i < 20; i++) begin
      step();
      check("erase_hold", {28'd0, draw_req, draw_erase, food_eaten, food_valid}, 32'b1100);
      check("erase_hold_score", 32'(score), 32'd1);
    end

    // Release ERASE; then four rejected candidates followed by a good one.
    head_valid = 1'b0;
    snakeX     = 10'd150;
    snakeY     = 9'd60;
    draw_ack   = 1'b1;
    step();
    check("back_to_spawn_req", 32'(draw_req), 32'd0);
    draw_ack = 1'b0;
    randomX = 10'd640; randomY = 9'd50;  step();
    check("rej_range", 32'(draw_req), 32'd0);
    randomX = 10'd105; randomY = 9'd50;  step();
    check("rej_grid", 32'(draw_req), 32'd0);
    randomX = 10'd150; randomY = 9'd60;  step();
    check("rej_head", 32'(draw_req), 32'd0);
    randomX = 10'd100; randomY = 9'd50;  step();
    check("rej_food", 32'(draw_req), 32'd0);
    check("rej_foodX_held", 32'(foodX), 32'd100);
    randomX = 10'd200; randomY = 9'd200; step();
    check("acc_foodX", 32'(foodX), 32'd200);
    check("acc_foodY", 32'(foodY), 32'd200);
    check("acc_draw_req", 32'(draw_req), 32'd1);
    check("acc_draw_erase", 32'(draw_erase), 32'd0);
    draw_ack = 1'b1;
    step();
    check("acc_valid", 32'(food_valid), 32'd1);

    // Eat at (200,200), then eight invalid samples with head on the default cell.
    draw_ack   = 1'b0;
    snakeX     = 10'd200;
    snakeY     = 9'd200;
    head_valid = 1'b1;
    step();
    check("eat2_score", 32'(score), 32'd2);
    head_valid = 1'b0;
    snakeX     = 10'd320;
    snakeY     = 9'd240;
    randomX    = 10'd105;
    randomY    = 9'd50;
    draw_ack   = 1'b1;
    step();
    draw_ack = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("fallback_pending", 32'(draw_req), 32'd0);
    step();
    check("fallback_foodX", 32'(foodX), 32'd330);
    check("fallback_foodY", 32'(foodY), 32'd240);
    check("fallback_draw_req", 32'(draw_req), 32'd1);

    // Drive score to saturation: 253 more eats bring it to 255.
    draw_ack = 1'b1;
    step();
    cur_x = 10'd330;
    cur_y = 9'd240;
    for (int i = 0; i < 253; i++) begin
      snakeX     = cur_x;
      snakeY     = cur_y;
      head_valid = 1'b1;
      step();
      head_valid = 1'b0;
      if (cur_x == 10'd10) begin
        randomX = 10'd20; randomY = 9'd20;
      end else begin
        randomX = 10'd10; randomY = 9'd10;
      end
      cur_x = randomX;
      cur_y = randomY;
      step();
      step();
      step();
    end
    check("sat_reach_255", 32'(score), 32'd255);
    check("sat_active", 32'(food_valid), 32'd1);
    snakeX     = cur_x;
    snakeY     = cur_y;
    head_valid = 1'b1;
    step();
    head_valid = 1'b0;
    check("sat_pulse", 32'(food_eaten), 32'd1);
    check("sat_hold_255", 32'(score), 32'd255);

    // Reset asynchronously while a DRAW request is pending.
    randomX = 10'd500;
    randomY = 9'd400;
    step();
    draw_ack = 1'b0;
    step();
    check("pre_rst_draw_req", 32'(draw_req), 32'd1);
    check("pre_rst_foodX", 32'(foodX), 32'd500);
    #5;
    resetn = 1'b0;
    #1;
    check("async_rst_draw_req", 32'(draw_req), 32'd0);
    check("async_rst_score", 32'(score), 32'd0);
    check("async_rst_foodX", 32'(foodX), 32'd320);
    check("async_rst_foodY", 32'(foodY), 32'd240);
    step();
    resetn  = 1'b1;
    randomX = 10'd105;
    step();
    check("post_rst_no_pulse", 32'(food_eaten), 32'd0);
    check("post_rst_no_req", 32'(draw_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
